// File: rtl/cond_flag_unit.sv
// cond_flag_unit: holds the architectural NZCV flags written by ADDS/SUBS,
// resolves B, B.cond and CBZ/CBNZ one cycle after EX into a registered
// decision for the fetch redirect, and keeps saturating branch statistics.
module cond_flag_unit #(
  parameter int CNT_W        = 32,
  parameter int NUM_BR_TYPES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             set_flags,
  input  logic [1:0]       br_type,
  input  logic             cb_invert,
  input  logic [3:0]       cond,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic [3:0]       flags_q,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // The br_type encoding is fixed at two bits; catch a mismatched override early.
  if (NUM_BR_TYPES != 4) begin : g_br_types_check
    $error("cond_flag_unit: NUM_BR_TYPES must be 4");
  end

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_CB   = 2'b10,
    BR_COND = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_HS = 4'h2, CC_LO = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  br_type_e br_kind;
  cond_e    cc;
  logic     acc;
  logic     decide;
  logic     cond_true;
  logic     taken_next;
  logic     flag_n, flag_z, flag_c, flag_v;

  assign br_kind = br_type_e'(br_type);
  assign cc      = cond_e'(cond);

  // A flush kills the EX instruction even when a stall is also present.
  assign acc    = ex_valid & ~stall & ~flush;
  assign decide = acc & (br_kind != BR_NONE);

  // Conditions read the registered flags; B.cond never shares a cycle with
  // a flag-setting op, so no bypass from the ALU is needed.
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Evaluate the B.cond condition code against the current NZCV.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    cond_true = 1'b1;
    unique case (cc)
      CC_EQ: cond_true = flag_z;
      CC_NE: cond_true = ~flag_z;
      CC_HS: cond_true = flag_c;
      CC_LO: cond_true = ~flag_c;
      CC_MI: cond_true = flag_n;
      CC_PL: cond_true = ~flag_n;
      CC_VS: cond_true = flag_v;
      CC_VC: cond_true = ~flag_v;
      CC_HI: cond_true = flag_c & ~flag_z;
      CC_LS: cond_true = ~(flag_c & ~flag_z);
      CC_GE: cond_true = (flag_n == flag_v);
      CC_LT: cond_true = (flag_n != flag_v);
      CC_GT: cond_true = ~flag_z & (flag_n == flag_v);
      CC_LE: cond_true = ~(~flag_z & (flag_n == flag_v));
      CC_AL: cond_true = 1'b1;
      CC_NV: cond_true = 1'b1;
    endcase
  end

  // Select the taken outcome by branch kind; CBZ/CBNZ use the ALU's
  // PASS_B zero result directly and never look at the flags.
  always_comb begin
    taken_next = 1'b0;
    unique case (br_kind)
      BR_NONE: taken_next = 1'b0;
      BR_B:    taken_next = 1'b1;
      BR_CB:   taken_next = alu_zero ^ cb_invert;
      BR_COND: taken_next = cond_true;
    endcase
  end

  // Architectural flag register, written only by accepted flag-setting ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: registers are assigned with <= so every flop samples the
      // pre-edge values of its neighbours, independent of block order.
      flags_q <= 4'b0000;
    end else if (acc && set_flags) begin
      flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    end
  end

  // Decision register: load on a new branch, hold under stall, else clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else if (decide) begin
      br_valid <= 1'b1;
      br_taken <= taken_next;
    end else if (!stall) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end
  end

  // Saturating statistics, stepped only when a new decision is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (decide) begin
      if (br_count != '1) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (taken_next && (taken_count != '1)) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed and randomized stimulus with a scoreboard.
// The bench plays the ALU (computes SUBS flags with 65-bit arithmetic) and
// predicts branch outcomes from the compared operands themselves.
module tb_cond_flag_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum int { OP_NOP, OP_SUBS, OP_B, OP_CB, OP_BC } op_e;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ex_valid = 1'b0, stall = 1'b0, flush = 1'b0, set_flags = 1'b0;
  logic [1:0]       br_type = 2'b00;
  logic             cb_invert = 1'b0;
  logic [3:0]       cond = 4'h0;
  logic             alu_negative = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0, alu_carry_out = 1'b0;
  logic [3:0]       flags_q;
  logic             br_valid, br_taken;
  logic [CNT_W-1:0] br_count, taken_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          exp_q[$];
  logic [3:0]  m_flags = 4'b0000;
  logic [63:0] m_a = '0, m_b = '0;
  bit          have_cmp = 1'b0;
  bit          m_valid = 1'b0;
  int          m_br = 0, m_tk = 0;

  cond_flag_unit #(.CNT_W(CNT_W), .NUM_BR_TYPES(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .set_flags(set_flags), .br_type(br_type), .cb_invert(cb_invert), .cond(cond),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .flags_q(flags_q), .br_valid(br_valid),
    .br_taken(br_taken), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome of B.cond after "SUBS a, b", from the comparison it encodes.
  function automatic bit cond_model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    bit ovf;
    r   = a - b;
    ovf = (a[63] != b[63]) && (r[63] != a[63]);
    case (c)
      4'h0: return a == b;
      4'h1: return a != b;
      4'h2: return a >= b;
      4'h3: return a < b;
      4'h4: return r[63];
      4'h5: return !r[63];
      4'h6: return ovf;
      4'h7: return !ovf;
      4'h8: return a > b;
      4'h9: return a <= b;
      4'hA: return $signed(a) >= $signed(b);
      4'hB: return $signed(a) < $signed(b);
      4'hC: return $signed(a) > $signed(b);
      4'hD: return $signed(a) <= $signed(b);
      default: return 1'b1;
    endcase
  endfunction

  // One EX cycle: drive, predict, clock, compare state outputs.
  task automatic step(input op_e op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] cnd, input logic cbn,
                      input logic v, input logic st, input logic fl);
    logic [64:0] sum;
    logic [3:0]  f;
    bit acc, tk, is_br;
    sum = {1'b0, a} + {1'b0, ~b} + 65'd1;
    f   = {sum[63], sum[63:0] == 64'd0, sum[64], (a[63] ^ b[63]) & (sum[63] ^ a[63])};
    ex_valid  = v;
    stall     = st;
    flush     = fl;
    cond      = cnd;
    cb_invert = cbn;
    set_flags = (op == OP_SUBS);
    case (op)
      OP_B:    br_type = 2'b01;
      OP_CB:   br_type = 2'b10;
      OP_BC:   br_type = 2'b11;
      default: br_type = 2'b00;
    endcase
    if (op == OP_SUBS) begin
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = f;
    end else begin
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'($urandom);
      if (op == OP_CB) alu_zero = (a == 64'd0);
    end
    acc   = v && !st && !fl;
    is_br = (op == OP_B) || (op == OP_CB) || (op == OP_BC);
    case (op)
      OP_CB:   tk = cbn ? (a != 64'd0) : (a == 64'd0);
      OP_BC:   tk = cond_model(cnd, m_a, m_b);
      default: tk = 1'b1;
    endcase
    if (acc && op == OP_SUBS) begin
      m_flags  = f;
      m_a      = a;
      m_b      = b;
      have_cmp = 1'b1;
    end
    if (acc && is_br) begin
      exp_q.push_back(tk);
      m_valid = 1'b1;
      if (m_br < CNT_MAX) m_br++;
      if (tk && m_tk < CNT_MAX) m_tk++;
    end else if (!st) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("flags_q", flags_q, m_flags);
    check("br_valid", br_valid, m_valid);
    check("br_count", br_count, m_br);
    check("taken_count", taken_count, m_tk);
  endtask

  // Assert reset between edges and confirm everything clears at once.
  task automatic do_reset();
    #1;
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0; set_flags = 1'b0; br_type = 2'b00;
    reset = 1'b1;
    #1;
    check("rst_flags", flags_q, 4'b0000);
    check("rst_br_valid", br_valid, 1'b0);
    check("rst_br_taken", br_taken, 1'b0);
    check("rst_br_count", br_count, 0);
    check("rst_taken_count", taken_count, 0);
    exp_q.delete();
    m_flags = 4'b0000; have_cmp = 1'b0; m_valid = 1'b0; m_br = 0; m_tk = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: each freshly loaded decision is popped and compared.
  initial begin : monitor
    logic st_at_edge;
    forever begin
      @(posedge clk);
      st_at_edge = stall;
      #1;
      if (!reset) begin
        if (br_valid && !st_at_edge) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_decision: got br_valid=1, expected no decision");
          end else begin
            check("br_taken", br_taken, exp_q.pop_front());
          end
        end else if (!br_valid) begin
          check("taken_idle", br_taken, 1'b0);
        end
      end
    end
  end

  // Driver: directed plan, then randomized blocks separated by resets.
  initial begin : driver
    logic [63:0] ra, rb;
    op_e op;
    #3;
    check("init_flags", flags_q, 4'b0000);
    check("init_br_valid", br_valid, 1'b0);
    check("init_br_count", br_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Equal compare, then EQ / NE
    step(OP_SUBS, 64'd5, 64'd5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flags_eq_case", flags_q, 4'b0110);
    step(OP_BC, '0, '0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_BC, '0, '0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Negative result: LT, GE, GT, LE
    step(OP_SUBS, 64'hC, 64'h10, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flags_neg_case", flags_q, 4'b1000);
    for (int c = 10; c <= 13; c++) step(OP_BC, '0, '0, 4'(c), 1'b0, 1'b1, 1'b0, 1'b0);
    // Signed overflow: VS, HI
    step(OP_SUBS, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flags_ovf_case", flags_q, 4'b0011);
    step(OP_BC, '0, '0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_BC, '0, '0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    // CBZ / CBNZ with Rt == 0; flags untouched
    step(OP_CB, 64'd0, '0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_CB, 64'd0, '0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flags_after_cb", flags_q, 4'b0011);
    // Flag write blocked by stall, by flush, and by both
    step(OP_SUBS, 64'd1, 64'd1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(OP_SUBS, 64'd1, 64'd1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(OP_SUBS, 64'd1, 64'd1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("flags_blocked", flags_q, 4'b0011);
    // B then three stalled cycles: decision holds, counted once
    step(OP_B, '0, '0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(OP_B, '0, '0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("stall_hold_taken", br_taken, 1'b1);
    step(OP_NOP, '0, '0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation with 17 taken B's, then reset mid-stream
    do_reset();
    for (int i = 0; i < 17; i++) step(OP_B, '0, '0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sat_br_count", br_count, 4'hF);
    check("sat_taken_count", taken_count, 4'hF);
    do_reset();

    // Randomized blocks
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 150; i++) begin
        op = op_e'($urandom_range(0, 4));
        if (op == OP_BC && !have_cmp) op = OP_SUBS;
        ra = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: rb = ra;
          1: begin ra = 64'($urandom_range(0, 20)); rb = 64'($urandom_range(0, 20)); end
          2: rb = {~ra[63], 63'($urandom)};
          default: rb = {$urandom, $urandom};
        endcase
        if (op == OP_CB && $urandom_range(0, 1) == 0) ra = 64'd0;
        step(op, ra, rb, 4'($urandom), 1'($urandom),
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
             ($urandom_range(0, 9) == 0));
      end
      do_reset();
    end

    for (int i = 0; i < 3; i++) step(OP_NOP, '0, '0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
